sram_stage_sequencer: RTL and testbench
=======================================

SRAM_STAGE_SEQUENCER -- requirements
Module: sram_stage_sequencer

Interface
REQ-001 Parameter NUM_STAGES, default 2, number of processing stages run after an upload.
REQ-002 Parameter ADDR_W, default 18, SRAM address width.
REQ-003 Parameter DATA_W, default 16, SRAM data width.
REQ-004 Parameter RX_TIMEOUT, default 50000000, idle cycles that end an upload.
REQ-005 Parameter STAGE_TIMEOUT, default 16777215, watchdog limit in cycles per stage.
REQ-006 Clock  in  1  single clock; all logic on its rising edge.
REQ-007 Reset  in  1  synchronous, active-high reset.
REQ-008 Rx_line  in  1  UART receive line; low means a start bit.
REQ-009 Rx_address / Rx_write_data / Rx_we_n  in  ADDR_W / DATA_W / 1  SRAM request from the UART unit.
REQ-010 Stage_address / Stage_write_data  in  NUM_STAGES*ADDR_W / NUM_STAGES*DATA_W  stage requests, flattened, stage k in slice k.
REQ-011 Stage_we_n / Stage_end  in  NUM_STAGES / NUM_STAGES  per-stage write enable (active low) and done flag.
REQ-012 Disp_address  in  ADDR_W  VGA read address.
REQ-013 Rx_initialize / Rx_enable  out  1 / 1  UART unit control.
REQ-014 Stage_start  out  NUM_STAGES  one-hot run request per stage.
REQ-015 Disp_enable  out  1  VGA enable.
REQ-016 SRAM_address / SRAM_write_data / SRAM_we_n  out  ADDR_W / DATA_W / 1  muxed SRAM request.
REQ-017 Active_stage  out  $clog2(NUM_STAGES)  index of the running stage; Busy  out  1  high when the state is not IDLE.
REQ-018 Stage_error  out  NUM_STAGES  sticky per-stage watchdog flags.

Function
REQ-019 The state machine SHALL have the states IDLE, RX and RUN.
REQ-020 In IDLE, Disp_enable=1; when Rx_line=0 the block SHALL go to RX, pulse Rx_initialize for 1 cycle, clear the timer and set Disp_enable=0.
REQ-021 In RX, Rx_enable SHALL be high exactly 1 cycle, the cycle after Rx_initialize.
REQ-022 In RX, the timer SHALL increment every cycle and clear on any cycle with Rx_we_n=0.
REQ-023 When the timer equals RX_TIMEOUT-1, the block SHALL go to RUN with Active_stage=0 and clear the timer.
REQ-024 In RUN, Stage_start[Active_stage] SHALL be registered high from the first RUN cycle; all other bits SHALL be 0.
REQ-025 Stage_end[k] SHALL be accepted only when Stage_start[k]=1 is already registered; Stage_end on any other bit SHALL be ignored.
REQ-026 On acceptance, Stage_start[k] SHALL drop on the next edge; Active_stage SHALL advance to k+1, whose start rises on the same edge; after stage NUM_STAGES-1 the block SHALL go to IDLE.
REQ-027 Mux: RX selects the Rx_* request; RUN selects stage slice Active_stage; IDLE selects Disp_address with write data 0 and SRAM_we_n=1.
REQ-028 The mux SHALL be purely combinational from the registered state, with zero added latency.
REQ-029 Rx_line activity outside IDLE SHALL be ignored.
REQ-030 The timer SHALL be $clog2(max(RX_TIMEOUT,STAGE_TIMEOUT)+1) bits wide and SHALL never wrap before its compare value.

Reset
REQ-031 Reset SHALL force: state IDLE, timer 0, Active_stage 0, Stage_start 0, Rx_initialize 0, Rx_enable 0, Disp_enable 1, Stage_error 0.
REQ-032 Reset asserted mid-RX or mid-RUN SHALL abort on the next edge with no residual start pulse.

Configuration
REQ-033 With macro STAGE_WATCHDOG_EN defined, the timer SHALL count in RUN, clearing on each stage advance.
REQ-034 With STAGE_WATCHDOG_EN, reaching STAGE_TIMEOUT-1 SHALL set Stage_error[k] and advance exactly as an accepted end.
REQ-035 With STAGE_WATCHDOG_EN, Stage_error SHALL clear on entry to RX.
REQ-036 Without STAGE_WATCHDOG_EN, RUN SHALL wait indefinitely for Stage_end and Stage_error SHALL be constant 0.

Structure
REQ-037 A shared package SHALL hold the state enum (IDLE, RX, RUN) and the default timeout constants.
REQ-038 One sub-module, seq_timeout_counter, SHALL implement the clearable timer with its compare output.

Verification (NUM_STAGES=3, RX_TIMEOUT=100, STAGE_TIMEOUT=50)
REQ-039 Rx_line low 1 cycle -> Rx_initialize high cycle 1, Rx_enable high cycle 2, Disp_enable 0.
REQ-040 Rx_we_n low at RX cycle 60, then high -> RUN entered 100 cycles after that write; Stage_start=3'b001.
REQ-041 Stage_end pulses in order 0, 1, 2 -> Stage_start 001, 010, 100, 000; state IDLE; Disp_enable 1; SRAM_address=Disp_address.
REQ-042 Stage_end[2] asserted while stage 0 runs -> ignored; Active_stage stays 0; SRAM_address=stage 0 slice.
REQ-043 With STAGE_WATCHDOG_EN, stage 1 never ends -> after 50 cycles Stage_error=3'b010 and Stage_start=3'b100; the next RX clears it.
REQ-044 Reset asserted in RUN stage 1 -> next edge Stage_start=0, state IDLE, SRAM_we_n=1.

Source files
------------

// File: rtl/sram_stage_sequencer_pkg.sv
// Shared state encoding, default timeout constants and width helper for the SRAM stage sequencer.
// Purely declarative: adds no latency and has no flow control of its own.
package sram_stage_sequencer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RX   = 2'd1,
    RUN  = 2'd2
  } state_t;

  localparam int unsigned DEF_RX_TIMEOUT    = 32'd50000000;
  localparam int unsigned DEF_STAGE_TIMEOUT = 32'd16777215;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sram_stage_sequencer_timeout_counter.sv
// Clearable up-counter that saturates at its compare value; hit is combinational from the count.
// Clear has priority over counting; no backpressure.
module seq_timeout_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         enable,
  input  logic [W-1:0] limit,
  output logic [W-1:0] count,
  output logic         hit
);

  assign hit = (count == limit);

  // Holding at the limit keeps the counter from ever wrapping past its compare point.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !hit) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/sram_stage_sequencer.sv
// Sequences UART upload then NUM_STAGES processing stages and muxes their SRAM requests (mux adds 0 cycles).
// Stages advance only on Stage_end from the running stage; STAGE_WATCHDOG_EN adds a per-stage timeout.
module sram_stage_sequencer
  import sram_stage_sequencer_pkg::*;
#(
  parameter int          NUM_STAGES    = 2,
  parameter int          ADDR_W        = 18,
  parameter int          DATA_W        = 16,
  parameter int unsigned RX_TIMEOUT    = DEF_RX_TIMEOUT,
  parameter int unsigned STAGE_TIMEOUT = DEF_STAGE_TIMEOUT,
  localparam int         SW            = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1
) (
  input  logic                         Clock,
  input  logic                         Reset,
  input  logic                         Rx_line,
  input  logic [ADDR_W-1:0]            Rx_address,
  input  logic [DATA_W-1:0]            Rx_write_data,
  input  logic                         Rx_we_n,
  input  logic [NUM_STAGES*ADDR_W-1:0] Stage_address,
  input  logic [NUM_STAGES*DATA_W-1:0] Stage_write_data,
  input  logic [NUM_STAGES-1:0]        Stage_we_n,
  input  logic [NUM_STAGES-1:0]        Stage_end,
  input  logic [ADDR_W-1:0]            Disp_address,
  output logic                         Rx_initialize,
  output logic                         Rx_enable,
  output logic [NUM_STAGES-1:0]        Stage_start,
  output logic                         Disp_enable,
  output logic [ADDR_W-1:0]            SRAM_address,
  output logic [DATA_W-1:0]            SRAM_write_data,
  output logic                         SRAM_we_n,
  output logic [SW-1:0]                Active_stage,
  output logic                         Busy,
  output logic [NUM_STAGES-1:0]        Stage_error
);

  localparam int              TW          = $clog2(max_u(RX_TIMEOUT, STAGE_TIMEOUT) + 1);
  localparam logic [SW-1:0]   LAST        = SW'(NUM_STAGES - 1);
  localparam logic [TW-1:0]   RX_LIMIT    = TW'(RX_TIMEOUT - 1);
  localparam logic [TW-1:0]   STAGE_LIMIT = TW'(STAGE_TIMEOUT - 1);

  state_t                  state;
  state_t                  state_nxt;
  logic [SW-1:0]           active_nxt;
  logic [NUM_STAGES-1:0]   start_nxt;
  logic                    rx_init_nxt;
  logic                    rx_en_nxt;
  logic                    accepted;
  logic                    wd_expire;
  logic                    wd_count;
  logic                    tmr_clear;
  logic                    tmr_enable;
  logic                    tmr_hit;
  logic [TW-1:0]           tmr_limit;
  logic [TW-1:0]           tmr_count;

  seq_timeout_counter #(.W(TW)) u_timer (
    .clk    (Clock),
    .rst    (Reset),
    .clear  (tmr_clear),
    .enable (tmr_enable),
    .limit  (tmr_limit),
    .count  (tmr_count),
    .hit    (tmr_hit)
  );

  // Only the running stage's own done flag counts; ends from idle stages are dropped.
  assign accepted = (state == RUN) && Stage_start[Active_stage] && Stage_end[Active_stage];

`ifdef STAGE_WATCHDOG_EN
  assign wd_count  = 1'b1;
  assign wd_expire = (state == RUN) && tmr_hit && !accepted;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      Stage_error <= '0;
    end else if (state == IDLE && !Rx_line) begin
      Stage_error <= '0;
    end else if (wd_expire) begin
      Stage_error[Active_stage] <= 1'b1;
    end
  end
`else
  assign wd_count    = 1'b0;
  assign wd_expire   = 1'b0;
  assign Stage_error = '0;
`endif

  always_comb begin
    state_nxt   = state;
    active_nxt  = Active_stage;
    rx_init_nxt = 1'b0;
    rx_en_nxt   = 1'b0;
    tmr_clear   = 1'b0;
    tmr_enable  = 1'b0;
    tmr_limit   = RX_LIMIT;
    case (state)
      IDLE: begin
        tmr_clear = 1'b1;
        if (!Rx_line) begin
          state_nxt   = RX;
          rx_init_nxt = 1'b1;
        end
      end
      RX: begin
        tmr_enable = 1'b1;
        rx_en_nxt  = Rx_initialize;
        // A write in progress always restarts the idle window, even at the limit.
        if (!Rx_we_n) begin
          tmr_clear = 1'b1;
        end else if (tmr_hit) begin
          state_nxt  = RUN;
          active_nxt = '0;
          tmr_clear  = 1'b1;
        end
      end
      RUN: begin
        tmr_limit  = STAGE_LIMIT;
        tmr_enable = wd_count;
        if (accepted || wd_expire) begin
          tmr_clear = 1'b1;
          if (Active_stage == LAST) begin
            state_nxt  = IDLE;
            active_nxt = '0;
          end else begin
            active_nxt = Active_stage + 1'b1;
          end
        end
      end
      default: begin
        state_nxt  = IDLE;
        active_nxt = '0;
      end
    endcase

    start_nxt = '0;
    if (state_nxt == RUN) begin
      start_nxt[active_nxt] = 1'b1;
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state         <= IDLE;
      Active_stage  <= '0;
      Stage_start   <= '0;
      Rx_initialize <= 1'b0;
      Rx_enable     <= 1'b0;
      Disp_enable   <= 1'b1;
    end else begin
      state         <= state_nxt;
      Active_stage  <= active_nxt;
      Stage_start   <= start_nxt;
      Rx_initialize <= rx_init_nxt;
      Rx_enable     <= rx_en_nxt;
      Disp_enable   <= (state_nxt == IDLE);
    end
  end

  assign Busy = (state != IDLE);

  always_comb begin
    SRAM_address    = Disp_address;
    SRAM_write_data = '0;
    SRAM_we_n       = 1'b1;
    case (state)
      RX: begin
        SRAM_address    = Rx_address;
        SRAM_write_data = Rx_write_data;
        SRAM_we_n       = Rx_we_n;
      end
      RUN: begin
        SRAM_address    = Stage_address[Active_stage*ADDR_W +: ADDR_W];
        SRAM_write_data = Stage_write_data[Active_stage*DATA_W +: DATA_W];
        SRAM_we_n       = Stage_we_n[Active_stage];
      end
      default: begin
        SRAM_address    = Disp_address;
        SRAM_write_data = '0;
        SRAM_we_n       = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_sram_stage_sequencer.sv
// Directed bench for sram_stage_sequencer with NUM_STAGES=3, RX_TIMEOUT=100, STAGE_TIMEOUT=50.
// Honors STAGE_WATCHDOG_EN to select watchdog or wait-forever expectations.
module tb_sram_stage_sequencer;

  localparam int NS = 3;
  localparam int AW = 18;
  localparam int DW = 16;

  localparam logic [AW-1:0] SA0  = 18'h01234;
  localparam logic [AW-1:0] SA1  = 18'h2ABCD;
  localparam logic [AW-1:0] SA2  = 18'h3F00F;
  localparam logic [DW-1:0] SD0  = 16'hA0A0;
  localparam logic [DW-1:0] SD1  = 16'h1B1B;
  localparam logic [DW-1:0] SD2  = 16'hC2C2;
  localparam logic [AW-1:0] DISP = 18'h0BEEF;
  localparam logic [AW-1:0] RXA  = 18'h15555;
  localparam logic [DW-1:0] RXD  = 16'h5A5A;

  logic               Clock = 1'b0;
  logic               Reset;
  logic               Rx_line;
  logic [AW-1:0]      Rx_address;
  logic [DW-1:0]      Rx_write_data;
  logic               Rx_we_n;
  logic [NS*AW-1:0]   Stage_address;
  logic [NS*DW-1:0]   Stage_write_data;
  logic [NS-1:0]      Stage_we_n;
  logic [NS-1:0]      Stage_end;
  logic [AW-1:0]      Disp_address;
  logic               Rx_initialize;
  logic               Rx_enable;
  logic [NS-1:0]      Stage_start;
  logic               Disp_enable;
  logic [AW-1:0]      SRAM_address;
  logic [DW-1:0]      SRAM_write_data;
  logic               SRAM_we_n;
  logic [1:0]         Active_stage;
  logic               Busy;
  logic [NS-1:0]      Stage_error;

  int vectors     = 0;
  int miscompares = 0;

  always #5 Clock = ~Clock;

  sram_stage_sequencer #(
    .NUM_STAGES    (NS),
    .ADDR_W        (AW),
    .DATA_W        (DW),
    .RX_TIMEOUT    (100),
    .STAGE_TIMEOUT (50)
  ) dut (
    .Clock            (Clock),
    .Reset            (Reset),
    .Rx_line          (Rx_line),
    .Rx_address       (Rx_address),
    .Rx_write_data    (Rx_write_data),
    .Rx_we_n          (Rx_we_n),
    .Stage_address    (Stage_address),
    .Stage_write_data (Stage_write_data),
    .Stage_we_n       (Stage_we_n),
    .Stage_end        (Stage_end),
    .Disp_address     (Disp_address),
    .Rx_initialize    (Rx_initialize),
    .Rx_enable        (Rx_enable),
    .Stage_start      (Stage_start),
    .Disp_enable      (Disp_enable),
    .SRAM_address     (SRAM_address),
    .SRAM_write_data  (SRAM_write_data),
    .SRAM_we_n        (SRAM_we_n),
    .Active_stage     (Active_stage),
    .Busy             (Busy),
    .Stage_error      (Stage_error)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic pulse_end(input logic [NS-1:0] e);
    Stage_end = e;
    step();
    Stage_end = '0;
  endtask

  task automatic wait_run();
    int n;
    n = 0;
    while (Stage_start == '0 && n < 300) begin
      step();
      n++;
    end
    check("run_entry_start", 32'(Stage_start), 32'h1);
  endtask

  initial begin
    Reset            = 1'b1;
    Rx_line          = 1'b1;
    Rx_address       = RXA;
    Rx_write_data    = RXD;
    Rx_we_n          = 1'b1;
    Stage_address    = {SA2, SA1, SA0};
    Stage_write_data = {SD2, SD1, SD0};
    Stage_we_n       = 3'b101;
    Stage_end        = '0;
    Disp_address     = DISP;
    steps(2);

    check("rst_busy",      32'(Busy),          32'h0);
    check("rst_disp_en",   32'(Disp_enable),   32'h1);
    check("rst_start",     32'(Stage_start),   32'h0);
    check("rst_rx_init",   32'(Rx_initialize), 32'h0);
    check("rst_rx_en",     32'(Rx_enable),     32'h0);
    check("rst_error",     32'(Stage_error),   32'h0);
    check("rst_active",    32'(Active_stage),  32'h0);
    check("idle_addr",     32'(SRAM_address),  32'(DISP));
    check("idle_wdata",    32'(SRAM_write_data), 32'h0);
    check("idle_we_n",     32'(SRAM_we_n),     32'h1);

    Reset = 1'b0;
    step();
    check("idle_hold",     32'(Busy),          32'h0);

    // Start bit: one-cycle Rx_initialize, then one-cycle Rx_enable.
    Rx_line = 1'b0;
    step();
    Rx_line = 1'b1;
    check("rx_init_c1",    32'(Rx_initialize), 32'h1);
    check("rx_en_c1",      32'(Rx_enable),     32'h0);
    check("rx_disp_en",    32'(Disp_enable),   32'h0);
    check("rx_busy",       32'(Busy),          32'h1);
    step();
    check("rx_init_c2",    32'(Rx_initialize), 32'h0);
    check("rx_en_c2",      32'(Rx_enable),     32'h1);
    step();
    check("rx_en_c3",      32'(Rx_enable),     32'h0);
    Rx_line = 1'b0;
    step();
    Rx_line = 1'b1;
    check("rx_line_ignored", 32'(Rx_initialize), 32'h0);
    steps(55);

    Rx_we_n = 1'b0;
    #1;
    check("rx_mux_addr",   32'(SRAM_address),  32'(RXA));
    check("rx_mux_wdata",  32'(SRAM_write_data), 32'(RXD));
    check("rx_mux_we_n",   32'(SRAM_we_n),     32'h0);
    step();
    Rx_we_n = 1'b1;
    steps(99);
    check("rx_not_yet_run", 32'(Stage_start),  32'h0);
    check("rx_still_busy", 32'(Busy),          32'h1);
    step();
    check("run_start0",    32'(Stage_start),   32'h1);
    check("run_active0",   32'(Active_stage),  32'h0);
    check("run0_addr",     32'(SRAM_address),  32'(SA0));
    check("run0_wdata",    32'(SRAM_write_data), 32'(SD0));
    check("run0_we_n",     32'(SRAM_we_n),     32'h1);

    pulse_end(3'b100);
    check("stray_end_start", 32'(Stage_start), 32'h1);
    check("stray_end_active", 32'(Active_stage), 32'h0);
    check("stray_end_addr", 32'(SRAM_address), 32'(SA0));

    pulse_end(3'b001);
    check("adv1_start",    32'(Stage_start),   32'h2);
    check("adv1_active",   32'(Active_stage),  32'h1);
    check("run1_addr",     32'(SRAM_address),  32'(SA1));
    check("run1_we_n",     32'(SRAM_we_n),     32'h0);
    pulse_end(3'b010);
    check("adv2_start",    32'(Stage_start),   32'h4);
    check("adv2_active",   32'(Active_stage),  32'h2);
    check("run2_wdata",    32'(SRAM_write_data), 32'(SD2));
    pulse_end(3'b100);
    check("done_start",    32'(Stage_start),   32'h0);
    check("done_busy",     32'(Busy),          32'h0);
    check("done_disp_en",  32'(Disp_enable),   32'h1);
    check("done_addr",     32'(SRAM_address),  32'(DISP));

    // Second upload: stage 1 is left hanging.
    Rx_line = 1'b0;
    step();
    Rx_line = 1'b1;
    wait_run();
    pulse_end(3'b001);
    check("hang_start1",   32'(Stage_start),   32'h2);
`ifdef STAGE_WATCHDOG_EN
    steps(49);
    check("wd_before_start", 32'(Stage_start), 32'h2);
    check("wd_before_err", 32'(Stage_error),   32'h0);
    step();
    check("wd_err",        32'(Stage_error),   32'h2);
    check("wd_start2",     32'(Stage_start),   32'h4);
    pulse_end(3'b100);
    check("wd_idle",       32'(Busy),          32'h0);
    check("wd_err_sticky", 32'(Stage_error),   32'h2);
    Rx_line = 1'b0;
    step();
    Rx_line = 1'b1;
    check("wd_err_cleared", 32'(Stage_error),  32'h0);
    wait_run();
    pulse_end(3'b001);
    check("wd_rerun_start1", 32'(Stage_start), 32'h2);
`else
    steps(60);
    check("nowd_start1",   32'(Stage_start),   32'h2);
    check("nowd_err",      32'(Stage_error),   32'h0);
`endif

    // Reset in the middle of stage 1 aborts on the next edge.
    check("pre_rst_we_n",  32'(SRAM_we_n),     32'h0);
    Reset = 1'b1;
    step();
    check("abort_start",   32'(Stage_start),   32'h0);
    check("abort_busy",    32'(Busy),          32'h0);
    check("abort_we_n",    32'(SRAM_we_n),     32'h1);
    check("abort_disp_en", 32'(Disp_enable),   32'h1);
    Reset = 1'b0;
    step();
    check("post_abort_start", 32'(Stage_start), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
